// File: rtl/circbuf_extract_if.sv
// Window/issue bundle signals between the circular buffer, the extractor and decode.
// slave modport is the extractor side; master is the buffer/decode side.
interface circbuf_extract_if #(
    parameter int WIDTH     = 32,
    parameter int EXT_COUNT = 2,
    parameter int CNTW      = $clog2(EXT_COUNT + 1)
);
    logic [EXT_COUNT-1:0]       ext_valid;
    logic [EXT_COUNT*WIDTH-1:0] in_elements;
    logic [EXT_COUNT-1:0]       in_barrier;
    logic [CNTW-1:0]            ext_consumed;
    logic                       flush;
    logic [EXT_COUNT-1:0]       out_valid;
    logic [EXT_COUNT*WIDTH-1:0] out_elements;
    logic                       out_ready;
    logic [31:0]                stall_cycles;
    logic [31:0]                starve_cycles;

    modport slave (
        input  ext_valid,
        input  in_elements,
        input  in_barrier,
        input  flush,
        input  out_ready,
        output ext_consumed,
        output out_valid,
        output out_elements,
        output stall_cycles,
        output starve_cycles
    );

    modport master (
        output ext_valid,
        output in_elements,
        output in_barrier,
        output flush,
        output out_ready,
        input  ext_consumed,
        input  out_valid,
        input  out_elements,
        input  stall_cycles,
        input  starve_cycles
    );
endinterface

// File: rtl/circbuf_extract.sv
// Takes an in-order prefix of the buffer window into a registered issue bundle.
// Optional perf counters enabled by CIRCBUF_EXTRACT_PERF_EN.
module circbuf_extract #(
    parameter int WIDTH     = 32,
    parameter int EXT_COUNT = 2,
    parameter int CNTW      = $clog2(EXT_COUNT + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    circbuf_extract_if.slave bus
);
    logic                       load_en;
    logic [CNTW-1:0]            take_n;
    logic [EXT_COUNT-1:0]       valid_d;
    logic [EXT_COUNT-1:0]       valid_q;
    logic [EXT_COUNT*WIDTH-1:0] elem_d;
    logic [EXT_COUNT*WIDTH-1:0] elem_q;

    assign load_en = (~|valid_q | bus.out_ready) & ~bus.flush;

    // Count leading valid slots; a barrier at slot 0 issues alone, later barriers cut the run.
    always_comb begin
        logic stop;
        take_n = '0;
        stop   = 1'b0;
        for (int i = 0; i < EXT_COUNT; i++) begin
            if (!stop) begin
                if (bus.ext_valid[i] && (i == 0 || !bus.in_barrier[i])) begin
                    take_n = take_n + CNTW'(1);
                    if (i == 0 && bus.in_barrier[0])
                        stop = 1'b1;
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

    // Next bundle: first take_n slots copied, the rest zeroed.
    always_comb begin
        valid_d = '0;
        elem_d  = '0;
        for (int i = 0; i < EXT_COUNT; i++) begin
            if (CNTW'(i) < take_n) begin
                valid_d[i]                = 1'b1;
                elem_d[i*WIDTH +: WIDTH] = bus.in_elements[i*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.ext_consumed = (load_en && reset_n) ? take_n : '0;

    // Bundle register: flush clears, load replaces, otherwise hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            elem_q  <= '0;
        end else if (bus.flush) begin
            valid_q <= '0;
            elem_q  <= '0;
        end else if (load_en) begin
            valid_q <= valid_d;
            elem_q  <= elem_d;
        end
    end

    assign bus.out_valid    = valid_q;
    assign bus.out_elements = elem_q;

`ifdef CIRCBUF_EXTRACT_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] starve_q;
    logic        stall_ev;
    logic        starve_ev;

    assign stall_ev  = |valid_q & ~bus.out_ready & ~bus.flush;
    assign starve_ev = load_en & ~bus.ext_valid[0];

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_q  <= '0;
            starve_q <= '0;
        end else begin
            if (stall_ev && stall_q != '1)
                stall_q <= stall_q + 32'd1;
            if (starve_ev && starve_q != '1)
                starve_q <= starve_q + 32'd1;
        end
    end

    assign bus.stall_cycles  = stall_q;
    assign bus.starve_cycles = starve_q;
`else
    assign bus.stall_cycles  = '0;
    assign bus.starve_cycles = '0;
`endif
endmodule

// File: tb/tb_circbuf_extract.sv
// Directed bench for circbuf_extract with hand-computed expectations.
// Counter expectations follow CIRCBUF_EXTRACT_PERF_EN.
module tb_circbuf_extract;
    localparam int WIDTH     = 32;
    localparam int EXT_COUNT = 2;

`ifdef CIRCBUF_EXTRACT_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [31:0] A = 32'hA000_0001;
    localparam logic [31:0] B = 32'hB000_0002;
    localparam logic [31:0] C = 32'hC000_0003;
    localparam logic [31:0] D = 32'hD000_0004;
    localparam logic [31:0] E = 32'hE000_0005;
    localparam logic [31:0] F = 32'hF000_0006;
    localparam logic [31:0] G = 32'h1234_0007;
    localparam logic [31:0] H = 32'h5678_0008;
    localparam logic [31:0] I = 32'h9ABC_0009;
    localparam logic [31:0] J = 32'hDEF0_000A;
    localparam logic [31:0] K = 32'h0F0F_000B;
    localparam logic [31:0] L = 32'hF0F0_000C;

    logic clock;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    circbuf_extract_if #(.WIDTH(WIDTH), .EXT_COUNT(EXT_COUNT)) bus ();

    circbuf_extract #(.WIDTH(WIDTH), .EXT_COUNT(EXT_COUNT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one window, check ext_consumed mid-cycle, then the bundle after the edge.
    task automatic cycle(input string tag,
                         input logic [1:0] v, input logic [1:0] bar,
                         input logic [63:0] el, input logic fl, input logic rdy,
                         input logic [1:0] e_cons, input logic [1:0] e_ov,
                         input logic [63:0] e_el);
        bus.ext_valid   = v;
        bus.in_barrier  = bar;
        bus.in_elements = el;
        bus.flush       = fl;
        bus.out_ready   = rdy;
        #1;
        chk({tag, ".cons"}, 64'(bus.ext_consumed), 64'(e_cons));
        tick();
        chk({tag, ".ov"}, 64'(bus.out_valid), 64'(e_ov));
        chk({tag, ".el"}, bus.out_elements, e_el);
    endtask

    initial begin
        n_cmp           = 0;
        n_err           = 0;
        reset_n         = 1'b0;
        bus.ext_valid   = 2'b11;
        bus.in_barrier  = 2'b00;
        bus.in_elements = {B, A};
        bus.flush       = 1'b0;
        bus.out_ready   = 1'b1;

        #3;
        chk("rst.ov", 64'(bus.out_valid), 64'd0);
        chk("rst.el", bus.out_elements, 64'd0);
        chk("rst.cons", 64'(bus.ext_consumed), 64'd0);
        chk("rst.stall", 64'(bus.stall_cycles), 64'd0);
        chk("rst.starve", 64'(bus.starve_cycles), 64'd0);

        #9;
        reset_n = 1'b1;
        cycle("full", 2'b11, 2'b00, {B, A}, 1'b0, 1'b1, 2'd2, 2'b11, {B, A});
        cycle("bar_hi", 2'b11, 2'b10, {D, C}, 1'b0, 1'b1, 2'd1, 2'b01, {32'd0, C});
        cycle("bar_lo", 2'b11, 2'b01, {F, E}, 1'b0, 1'b1, 2'd1, 2'b01, {32'd0, E});

        cycle("hold1", 2'b11, 2'b00, {H, G}, 1'b0, 1'b0, 2'd0, 2'b01, {32'd0, E});
        cycle("hold2", 2'b11, 2'b00, {H, G}, 1'b0, 1'b0, 2'd0, 2'b01, {32'd0, E});
        cycle("hold3", 2'b11, 2'b00, {H, G}, 1'b0, 1'b0, 2'd0, 2'b01, {32'd0, E});
        chk("stall3", 64'(bus.stall_cycles), PERF ? 64'd3 : 64'd0);
        cycle("release", 2'b11, 2'b00, {H, G}, 1'b0, 1'b1, 2'd2, 2'b11, {H, G});
        chk("stall_keep", 64'(bus.stall_cycles), PERF ? 64'd3 : 64'd0);
        chk("starve0", 64'(bus.starve_cycles), 64'd0);

        cycle("nonpre", 2'b10, 2'b00, {J, I}, 1'b0, 1'b1, 2'd0, 2'b00, 64'd0);
        chk("starve1", 64'(bus.starve_cycles), PERF ? 64'd1 : 64'd0);
        cycle("empty", 2'b00, 2'b00, {J, I}, 1'b0, 1'b0, 2'd0, 2'b00, 64'd0);
        chk("starve2", 64'(bus.starve_cycles), PERF ? 64'd2 : 64'd0);

        cycle("load_f", 2'b11, 2'b00, {J, I}, 1'b0, 1'b1, 2'd2, 2'b11, {J, I});
        cycle("flush1", 2'b11, 2'b00, {L, K}, 1'b1, 1'b1, 2'd0, 2'b00, 64'd0);
        cycle("load_g", 2'b11, 2'b00, {J, I}, 1'b0, 1'b1, 2'd2, 2'b11, {J, I});
        cycle("flush2", 2'b11, 2'b00, {L, K}, 1'b1, 1'b0, 2'd0, 2'b00, 64'd0);
        chk("stall_fl", 64'(bus.stall_cycles), PERF ? 64'd3 : 64'd0);
        chk("starve_fl", 64'(bus.starve_cycles), PERF ? 64'd2 : 64'd0);

        cycle("load_r", 2'b11, 2'b00, {L, K}, 1'b0, 1'b1, 2'd2, 2'b11, {L, K});
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst.ov", 64'(bus.out_valid), 64'd0);
        chk("arst.el", bus.out_elements, 64'd0);
        chk("arst.cons", 64'(bus.ext_consumed), 64'd0);
        chk("arst.stall", 64'(bus.stall_cycles), 64'd0);
        chk("arst.starve", 64'(bus.starve_cycles), 64'd0);
        #1;
        reset_n = 1'b1;
        cycle("resume", 2'b11, 2'b00, {B, A}, 1'b0, 1'b1, 2'd2, 2'b11, {B, A});
        cycle("resume2", 2'b01, 2'b00, {D, C}, 1'b0, 1'b1, 2'd1, 2'b01, {32'd0, C});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/circbuf_extract.md
Name: circbuf_extract

Overview:
- Consumer-side companion of the multi-entry circular instruction buffer.
- Each cycle it inspects the buffer's EXT_COUNT-wide output window and takes a contiguous in-order prefix of valid entries into a registered issue bundle.
- Returns the number taken on ext_consumed so the buffer advances its extract pointer.
- Sits between the buffer and decode; provides one-cycle registered latency, whole-bundle backpressure, a flush path and barrier (issue-alone) handling.

Parameters:
- WIDTH, 32, bits per element.
- EXT_COUNT, 2, window and bundle width in elements.
- CNTW, $clog2(EXT_COUNT+1), width of ext_consumed; must represent 0..EXT_COUNT inclusive.

Ports:
- clock, input, 1, single clock; all state updates on the rising edge.
- reset_n, input, 1, reset, asynchronous active-low.
- ext_valid, input, EXT_COUNT, per-slot valid from the buffer window; slot 0 is oldest.
- in_elements, input, EXT_COUNT*WIDTH, window elements; slot i occupies bits [i*WIDTH +: WIDTH].
- in_barrier, input, EXT_COUNT, per-slot flag: the element must issue alone in its bundle.
- ext_consumed, output, CNTW, combinational count of window entries taken this cycle.
- flush, input, 1, synchronous pipeline flush.
- out_valid, output, EXT_COUNT, registered per-slot valid of the issue bundle.
- out_elements, output, EXT_COUNT*WIDTH, registered bundle elements, compacted from slot 0.
- out_ready, input, 1, downstream accepts the entire bundle this cycle.
- stall_cycles, output, 32, back-pressure stall counter (see Optional Feature).
- starve_cycles, output, 32, empty-window starvation counter (see Optional Feature).

Behaviour:
- Reset (async, reset_n low): out_valid = 0, out_elements = 0, both counters = 0. ext_consumed reads 0 while in reset.
- load_en = (out_valid == 0 | out_ready) & ~flush.
- take count n, combinational:
  - n = number of leading set bits of ext_valid, starting at slot 0.
  - If in_barrier[0] & ext_valid[0], then n = 1.
  - Otherwise n is truncated before the first slot k > 0 with in_barrier[k] set.
  - Non-prefix ext_valid patterns (e.g. 2'b10) yield n = 0.
- ext_consumed = load_en ? n : 0.
- On load_en, at the clock edge:
  - Slots 0..n-1 load in_elements[0..n-1]; out_valid = (1<<n) - 1.
  - Slots >= n are zeroed.
  - If n = 0, the bundle becomes empty (out_valid = 0).
- Hold: out_valid != 0 & ~out_ready & ~flush → bundle and out_valid unchanged; ext_consumed = 0.
- Flush:
  - Clears out_valid and out_elements at the next edge.
  - ext_consumed = 0 in the flush cycle.
  - Takes priority over load and hold.
- Latency: a window entry appears on out_* exactly 1 cycle after the cycle it was counted in ext_consumed.
- Throughput: EXT_COUNT elements per cycle with out_ready held high and no barriers.
- Bundle acceptance is all-or-nothing; no partial drain.
- Window updates caused by ext_consumed are the buffer's responsibility; this block keeps no pointer state.
- Reset asserted mid-operation drops the bundle immediately; no element is reported as consumed in that cycle.

Optional Feature:
- Macro: CIRCBUF_EXTRACT_PERF_EN.
- Defined:
  - stall_cycles: saturating 32-bit counter, +1 each cycle with out_valid != 0 & ~out_ready & ~flush.
  - starve_cycles: saturating 32-bit counter, +1 each cycle with load_en & ~ext_valid[0].
  - Both counters clear only on reset and hold at 32'hFFFFFFFF.
- Undefined: both outputs are tied to 0; no counter flops are generated.

Test Plan:
- Reset, then ext_valid=2'b11, elements {B,A}, no barriers, out_ready=1 → ext_consumed=2 that cycle; next cycle out_valid=2'b11, out_elements={B,A}.
- ext_valid=2'b11, in_barrier=2'b10 → ext_consumed=1; next cycle out_valid=2'b01 with A only. Then in_barrier=2'b01 → ext_consumed=1 again, barrier element issues alone.
- Bundle valid, out_ready=0 for 3 cycles → ext_consumed=0 and bundle unchanged; with PERF_EN, stall_cycles=3. out_ready=1 → new window loaded the same cycle.
- ext_valid=2'b10 (non-prefix) → ext_consumed=0, bundle empty next cycle; with PERF_EN, starve_cycles increments.
- flush=1 while bundle valid and ext_valid=2'b11 → ext_consumed=0; out_valid=0 next cycle.
- reset_n pulsed low mid-stream, asynchronous to the clock → out_valid=0 immediately; counters=0; operation resumes normally after release.
